// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the instruction control block, the multiply/divide
// sequencer and the ALU/accumulator: sequencer states and select encodings.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_EVAL   = 3'd2,
        S_SHIFT  = 3'd3,
        S_DSHIFT = 3'd4,
        S_TRIAL  = 3'd5,
        S_DONE   = 3'd6
    } seq_state_e;

    // Accumulator half actions, identical encoding for the high and low halves.
    localparam logic [1:0] SEL_HOLD    = 2'b00;
    localparam logic [1:0] SEL_SHIFT_R = 2'b01;
    localparam logic [1:0] SEL_SHIFT_L = 2'b10;
    localparam logic [1:0] SEL_LOAD    = 2'b11;

endpackage

// File: rtl/mul_div_sequencer.sv
// Multi-cycle controller sequencing the ALU/accumulator through shift-add
// multiplication and restoring division, one ALU operation per iteration.
module mul_div_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int ITER = 4
) (
    input  logic              clk,
    input  logic              reset_p,
    input  logic              start,
    input  logic              is_div,
    input  logic [ITER-1:0]   breg_data,
    input  logic              acc_lsb,
    input  logic              sign_flag,
    output logic              op_add,
    output logic              op_sub,
    output logic              acc_high_reset_p,
    output logic [1:0]        acc_high_select_in,
    output logic [1:0]        acc_low_select,
    output logic              q_bit,
    output logic              busy,
    output logic              done,
    output logic              div0
);

    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             div0_q, div0_d;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            div0_q   <= div0_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        is_div_d           = is_div_q;
        div0_d             = div0_q;
        op_add             = 1'b0;
        op_sub             = 1'b0;
        acc_high_reset_p   = 1'b0;
        acc_high_select_in = SEL_HOLD;
        acc_low_select     = SEL_HOLD;
        q_bit              = 1'b0;
        done               = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_div && (breg_data == '0)) begin
                        div0_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        div0_d   = 1'b0;
                        is_div_d = is_div;
                        state_d  = S_CLEAR;
                    end
                end
            end

            S_CLEAR: begin
                acc_high_reset_p = 1'b1;
                cnt_d            = '0;
                state_d          = is_div_q ? S_DSHIFT : S_EVAL;
            end

            S_EVAL: begin
                op_add             = 1'b1;
                acc_high_select_in = acc_lsb ? SEL_LOAD : SEL_HOLD;
                state_d            = S_SHIFT;
            end

            S_SHIFT: begin
                acc_high_select_in = SEL_SHIFT_R;
                acc_low_select     = SEL_SHIFT_R;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_EVAL;
                end
            end

            S_DSHIFT: begin
                acc_high_select_in = SEL_SHIFT_L;
                acc_low_select     = SEL_SHIFT_L;
                state_d            = S_TRIAL;
            end

            S_TRIAL: begin
                // A non-negative trial difference is kept and yields a 1 quotient bit.
                op_sub             = 1'b1;
                acc_high_select_in = sign_flag ? SEL_HOLD : SEL_LOAD;
                acc_low_select     = SEL_LOAD;
                q_bit              = ~sign_flag;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_DSHIFT;
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A divide-by-zero goes straight from IDLE to DONE without owning the datapath.
    assign busy = (state_q != S_IDLE) && !((state_q == S_DONE) && div0_q);
    assign div0 = div0_q;

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Bench for mul_div_sequencer: behavioural accumulator/ALU around the DUT,
// directed operations, scoreboard queue popped by a done monitor.
module tb_mul_div_sequencer;
    import cpu_ctrl_pkg::*;

    logic       clk;
    logic       reset_p;
    logic       start;
    logic       is_div;
    logic [3:0] breg_data;
    logic       acc_lsb;
    logic       sign_flag;
    logic       op_add;
    logic       op_sub;
    logic       acc_high_reset_p;
    logic [1:0] acc_high_select_in;
    logic [1:0] acc_low_select;
    logic       q_bit;
    logic       busy;
    logic       done;
    logic       div0;

    mul_div_sequencer #(.ITER(4)) dut (
        .clk                (clk),
        .reset_p            (reset_p),
        .start              (start),
        .is_div             (is_div),
        .breg_data          (breg_data),
        .acc_lsb            (acc_lsb),
        .sign_flag          (sign_flag),
        .op_add             (op_add),
        .op_sub             (op_sub),
        .acc_high_reset_p   (acc_high_reset_p),
        .acc_high_select_in (acc_high_select_in),
        .acc_low_select     (acc_low_select),
        .q_bit              (q_bit),
        .busy               (busy),
        .done               (done),
        .div0               (div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accumulator model with a carry bit that feeds SHIFT_R after an add.
    logic [3:0] m_hi, m_lo;
    logic       m_c;
    logic       load_en;
    logic [3:0] load_hi, load_lo;
    logic [4:0] sum5, diff5;

    assign sum5      = {1'b0, m_hi} + {1'b0, breg_data};
    assign diff5     = {1'b0, m_hi} - {1'b0, breg_data};
    assign acc_lsb   = m_lo[0];
    assign sign_flag = diff5[4];

    always @(posedge clk) begin
        if (load_en) begin
            m_hi <= load_hi;
            m_lo <= load_lo;
            m_c  <= 1'b0;
        end else begin
            if (acc_high_reset_p) begin
                m_hi <= 4'h0;
                m_c  <= 1'b0;
            end else begin
                case (acc_high_select_in)
                    SEL_LOAD: begin
                        m_hi <= op_add ? sum5[3:0] : diff5[3:0];
                        m_c  <= op_add ? sum5[4] : 1'b0;
                    end
                    SEL_SHIFT_R: begin
                        m_hi <= {m_c, m_hi[3:1]};
                        m_c  <= 1'b0;
                    end
                    SEL_SHIFT_L: m_hi <= {m_hi[2:0], m_lo[3]};
                    default:     m_hi <= m_hi;
                endcase
            end
            case (acc_low_select)
                SEL_LOAD:    m_lo <= {m_lo[3:1], q_bit};
                SEL_SHIFT_R: m_lo <= {m_hi[0], m_lo[3:1]};
                SEL_SHIFT_L: m_lo <= {m_lo[2:0], 1'b0};
                default:     m_lo <= m_lo;
            endcase
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    typedef struct {
        logic [3:0] hi;
        logic [3:0] lo;
        logic       div0;
        int         start_cyc;
        int         lat;
    } exp_t;

    exp_t sb[$];

    // Free-running observation counters; the main thread compares deltas.
    int done_cnt     = 0;
    int busy_cnt     = 0;
    int add_cnt      = 0;
    int add_hold_cnt = 0;
    int excl_viol    = 0;

    always @(negedge clk) begin
        if (!reset_p) begin
            if (busy) busy_cnt++;
            if (op_add) add_cnt++;
            if (op_add && (acc_high_select_in == SEL_HOLD)) add_hold_cnt++;
            if (op_add && op_sub) excl_viol++;
            if (done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("acc_high", int'(m_hi), int'(e.hi));
                    check("acc_low", int'(m_lo), int'(e.lo));
                    check("div0", int'(div0), int'(e.div0));
                    check("done_cycle", cyc - e.start_cyc + 1, e.lat);
                end
            end
        end
    end

    task automatic op(input logic div, input logic [3:0] b, input logic [3:0] hi,
                      input logic [3:0] lo, input logic [3:0] ehi, input logic [3:0] elo,
                      input logic ediv0, input int elat);
        exp_t e;
        @(posedge clk);
        #1;
        start     = 1'b1;
        is_div    = div;
        breg_data = b;
        load_en   = 1'b1;
        load_hi   = hi;
        load_lo   = lo;
        e.hi        = ehi;
        e.lo        = elo;
        e.div0      = ediv0;
        e.start_cyc = cyc + 1;
        e.lat       = elat;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start   = 1'b0;
        load_en = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) break;
        end
        check(name, int'(done), 1);
    endtask

    function automatic logic [10:0] all_outs();
        return {op_add, op_sub, acc_high_reset_p, acc_high_select_in, acc_low_select,
                q_bit, busy, done, div0};
    endfunction

    int snap_a, snap_b, snap_d;

    initial begin
        reset_p   = 1'b1;
        start     = 1'b0;
        is_div    = 1'b0;
        breg_data = 4'h0;
        load_en   = 1'b0;
        load_hi   = 4'h0;
        load_lo   = 4'h0;
        m_hi      = 4'h0;
        m_lo      = 4'h0;
        m_c       = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_p = 1'b0;
        @(negedge clk);
        check("reset_outputs", int'(all_outs()), 0);

        // 15 x 15 = 225; busy spans CLEAR..DONE, ten cycles.
        snap_b = busy_cnt;
        op(1'b0, 4'hF, 4'h0, 4'hF, 4'hE, 4'h1, 1'b0, 10);
        wait_done("mul_ff_done");
        @(negedge clk);
        check("mul_ff_busy_cycles", busy_cnt - snap_b, 10);

        // 0 x 7: four EVALs add but keep the high half.
        snap_a = add_cnt;
        snap_d = add_hold_cnt;
        op(1'b0, 4'h7, 4'hA, 4'h0, 4'h0, 4'h0, 1'b0, 10);
        wait_done("mul_zero_done");
        @(negedge clk);
        check("mul_zero_add_cycles", add_cnt - snap_a, 4);
        check("mul_zero_add_hold", add_hold_cnt - snap_d, 4);

        // Divide by zero: immediate done, accumulator untouched, never busy.
        snap_b = busy_cnt;
        op(1'b1, 4'h0, 4'h5, 4'h9, 4'h5, 4'h9, 1'b1, 1);
        wait_done("div0_done");
        @(negedge clk);
        check("div0_busy_cycles", busy_cnt - snap_b, 0);

        // 13 / 3 = 4 rem 1; div0 cleared by this start.
        op(1'b1, 4'h3, 4'h0, 4'hD, 4'h1, 4'h4, 1'b0, 10);
        wait_done("div_13_3_done");
        @(negedge clk);

        // Start pulsed at cycle 5 of a busy multiply is ignored.
        snap_d = done_cnt;
        op(1'b0, 4'hF, 4'h0, 4'hF, 4'hE, 4'h1, 1'b0, 10);
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("mul_ignored_start_done");
        // Back-to-back: 14 / 5 = 2 rem 4, started in the IDLE cycle after done.
        op(1'b1, 4'h5, 4'h0, 4'hE, 4'h4, 4'h2, 1'b0, 10);
        wait_done("div_back_to_back_done");
        @(negedge clk);
        check("done_pulse_count", done_cnt - snap_d, 2);

        // Reset at cycle 6 of a divide abandons it.
        op(1'b1, 4'h3, 4'h0, 4'hD, 4'h0, 4'h0, 1'b0, 10);
        repeat (5) @(posedge clk);
        #1 reset_p = 1'b1;
        sb.delete();
        @(posedge clk);
        #1 reset_p = 1'b0;
        @(negedge clk);
        check("mid_op_reset_outputs", int'(all_outs()), 0);

        // 5 x 3 = 15 after the abandoned divide.
        op(1'b0, 4'h3, 4'h6, 4'h5, 4'h0, 4'hF, 1'b0, 10);
        wait_done("mul_after_reset_done");
        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        check("add_sub_exclusive", excl_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_div_sequencer.md
# mul_div_sequencer

Multi-cycle controller that drives the ALU/accumulator datapath through 4-bit × 4-bit shift-add multiplication and 4-bit ÷ 4-bit restoring division. It sits between the instruction control block and the ALU/accumulator. The control block loads operands, pulses `start`, and waits for `done`. While the sequencer is busy, it exclusively owns the accumulator select lines and the add/sub opcode lines.

## Interface
Parameters:
- `ITER`, default 4: operand width and iteration count; equals the accumulator half width.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_p`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `is_div`  in  1  sampled with `start`: 1 selects divide, 0 selects multiply.
- `breg_data`  in  ITER  divisor/multiplicand as held in BREG; used for the divide-by-zero check.
- `acc_lsb`  in  1  accumulator low-half bit 0 (current multiplier bit).
- `sign_flag`  in  1  ALU result-negative flag for the current ALU operation.
- `op_add`  out  1  ALU add request.
- `op_sub`  out  1  ALU subtract request.
- `acc_high_reset_p`  out  1  clears the accumulator high half.
- `acc_high_select_in`  out  2  high-half action.
- `acc_low_select`  out  2  low-half action.
- `q_bit`  out  1  quotient bit written into the low-half LSB.
- `busy`  out  1  high from CLEAR through DONE.
- `done`  out  1  one-cycle completion pulse.
- `div0`  out  1  divide-by-zero; valid while `done` is high.

## Operation
- Select encodings, both halves: 00 HOLD, 01 SHIFT_R, 10 SHIFT_L, 11 LOAD.
  - High LOAD takes the ALU result.
  - Low LOAD sets bit 0 to `q_bit`.
  - SHIFT_R moves high bit 0 into low bit ITER-1.
  - SHIFT_L moves low bit ITER-1 into high bit 0.
- States: IDLE, CLEAR, EVAL, SHIFT, DSHIFT, TRIAL, DONE. A 2-bit iteration counter `cnt` runs 0..ITER-1.
- IDLE:
  - `start`=1 and `is_div`=1 and `breg_data`==0 → DONE with `div0` latched to 1.
  - `start`=1 otherwise → CLEAR, with the operation latched.
- CLEAR: `acc_high_reset_p`=1 and `cnt`←0. Next state is EVAL (multiply) or DSHIFT (divide).
- Multiply:
  - EVAL: `op_add`=1. High select is LOAD if `acc_lsb`=1, else HOLD. Next state SHIFT.
  - SHIFT: both halves SHIFT_R. If `cnt`==ITER-1 → DONE, else `cnt`+1 → EVAL.
- Divide:
  - DSHIFT: both halves SHIFT_L. Next state TRIAL.
  - TRIAL: `op_sub`=1.
    - If `sign_flag`=0: high select LOAD and `q_bit`=1.
    - If `sign_flag`=1: high select HOLD and `q_bit`=0.
    - Low select is LOAD in both cases.
    - If `cnt`==ITER-1 → DONE, else `cnt`+1 → DSHIFT.
- DONE: `done`=1 for one cycle, then IDLE. `div0` is cleared on the next accepted `start`.
- Final results:
  - Multiply: 2·ITER-bit product across high:low.
  - Divide: remainder in high, quotient in low.
- Every output not listed for a state is 0. Both selects are 00 in IDLE.

## Timing
- Reset (synchronous) forces IDLE and `cnt`=0; `div0`=0, `busy`=0, `done`=0, and every other output is 0. A reset mid-operation abandons the operation; accumulator contents are then undefined to the caller.
- Latency, with `start` sampled at edge 0:
  - Normal operation: CLEAR in cycle 1, iterations in cycles 2..2·ITER+1, `done` in cycle 2·ITER+2 (cycle 10 for ITER=4).
  - Divide-by-zero: `done` in cycle 1.
- `busy` goes high the cycle after `start` is accepted and drops after DONE. IDLE is re-entered the cycle after `done`; `start` may be asserted in that cycle.
- `start` is ignored in every state other than IDLE, with no queuing.
- Outputs are decoded from state. The select lines in EVAL and TRIAL also depend combinationally on `acc_lsb`/`sign_flag` in the same cycle, because the ALU flags are valid combinationally from the current accumulator and BREG values.
- `op_add` and `op_sub` are never asserted in the same cycle.

## Structure
- A shared package `cpu_ctrl_pkg` holds:
  - the state enum;
  - the 2-bit select constants (HOLD/SHIFT_R/SHIFT_L/LOAD), shared with the ALU/accumulator block and the control block.
- No sub-modules: a single FSM plus counter, about 150–250 lines.

## Test plan
The bench uses a behavioural accumulator model implementing the package encodings.
- Multiply: acc low=4'hF, BREG=4'hF, `start`, `is_div`=0 → `done` at cycle 10 and acc=8'hE1.
- Multiply by zero: acc low=4'h0, BREG=4'h7 → acc=8'h00 and `op_add` high in 4 EVAL cycles with high select HOLD.
- Divide: low=4'hD, BREG=4'h3, `is_div`=1 → `done` at cycle 10, high=4'h1, low=4'h4, `div0`=0.
- Divide-by-zero: BREG=4'h0, `is_div`=1 → `done` and `div0`=1 at cycle 1; accumulator untouched; `busy` never asserted.
- `start` pulsed at cycle 5 of a busy multiply → ignored, with a single `done` at cycle 10. A back-to-back `start` in the cycle after `done` is accepted.
- `reset_p` asserted at cycle 6 of a divide → IDLE next cycle with all outputs 0; a new multiply afterwards completes correctly.
